// File: rtl/multiword_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module : multiword_add_ctrl
// Brief  : WORDS x 4-bit add/subtract sequenced over one shared 4-bit slice.
// Rev    : 1.0  initial release
// ============================================================================

module rippleAdder4b (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c
);
    logic [4:0] w_chain;

    assign w_chain[0] = i_c;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
        assign o_s[gi]         = i_a[gi] ^ i_b[gi] ^ w_chain[gi];
        assign w_chain[gi + 1] = (i_a[gi] & i_b[gi]) | (w_chain[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_c = w_chain[4];
endmodule

module multiword_add_ctrl #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sub,
    input  logic               cin,
    input  logic [4*WORDS-1:0] a_in,
    input  logic [4*WORDS-1:0] b_in,
    output logic               busy,
    output logic               done,
    output logic [4*WORDS-1:0] sum,
    output logic               cout,
    output logic               ovf
);
    localparam int N     = 4 * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] C_LAST = IDX_W'(WORDS - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [N-1:0]     r_shadow;
    logic [N-1:0]     r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_done;

    logic             w_busy;
    logic             w_accept;
    logic             w_last;
    logic [IDX_W+1:0] w_base;
    logic [3:0]       w_s;
    logic             w_c;
    logic [N-1:0]     w_final;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next_state = S_RUN;
            S_RUN:   if (w_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        w_busy   = (r_state == S_RUN);
        w_accept = (r_state == S_IDLE) && start;
        w_last   = (r_state == S_RUN) && (r_idx == C_LAST);
    end

    assign w_base = {r_idx, 2'b00};

    rippleAdder4b u_slice (
        .i_a (r_a[w_base +: 4]),
        .i_b (r_b[w_base +: 4]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_c)
    );

    // Completed result: shadow with the nibble being computed this cycle merged in
    always_comb begin
        w_final             = r_shadow;
        w_final[w_base +: 4] = w_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_shadow <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a     <= a_in;
                r_b     <= sub ? ~b_in : b_in;
                r_carry <= sub | cin;
                r_idx   <= '0;
            end else if (w_busy) begin
                r_shadow[w_base +: 4] <= w_s;
                r_carry               <= w_c;
                r_idx                 <= r_idx + 1'b1;
                if (w_last) begin
                    r_sum  <= w_final;
                    r_cout <= w_c;
                    // Overflow judged against the effective (possibly inverted) B
                    r_ovf  <= (r_a[N-1] == r_b[N-1]) && (w_s[3] != r_a[N-1]);
                end
            end
        end
    end

    assign busy = w_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;
endmodule

`default_nettype wire

// File: tb/tb_multiword_add_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_multiword_add_ctrl
// Brief  : Scoreboard bench for multiword_add_ctrl with WORDS=4.
// Rev    : 1.0  initial release
// ============================================================================

module tb_multiword_add_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t q[$];
    exp_t r_mon;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multiword_add_ctrl #(.WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic s, input logic ci);
        exp_t        m;
        logic [15:0] be;
        logic [16:0] r;
        be  = s ? ~b : b;
        r   = {1'b0, a} + {1'b0, be} + 17'(s ? 1'b1 : ci);
        m.s = r[15:0];
        m.c = r[16];
        m.o = (a[15] == be[15]) && (r[15] != a[15]);
        return m;
    endfunction

    // Scoreboard: every done pops one expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got sum=%h cout=%b ovf=%b, none expected", sum, cout, ovf);
            end else begin
                r_mon = q.pop_front();
                if ({sum, cout, ovf} !== {r_mon.s, r_mon.c, r_mon.o}) begin
                    errors++;
                    $display("FAIL result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                             sum, cout, ovf, r_mon.s, r_mon.c, r_mon.o);
                end
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL done_with_busy: got busy=%b, want 0", busy);
            end
        end
    end

    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s, input logic ci);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        sub   = s;
        cin   = ci;
        start = 1'b1;
        q.push_back(model(a, b, s, ci));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            if (busy === 1'b1) bc++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no done after %0d cycles, want done", n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, sum, cout, ovf} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, sum} !== 18'h0) begin
            errors++;
            $display("FAIL post_reset: got busy=%b done=%b sum=%h, want 0", busy, done, sum);
        end
    endtask

    task automatic test_add();
        int n, bc;
        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done(n, bc);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL add_latency: got %0d, want 4", n);
        end
        checks++;
        if (bc !== 4) begin
            errors++;
            $display("FAIL add_busy_cycles: got %0d, want 4", bc);
        end
        checks++;
        if (sum !== 16'h5555 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL add_value: got %h/%b/%b, want 5555/0/0", sum, cout, ovf);
        end
    endtask

    task automatic test_carry();
        int n, bc;
        launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done(n, bc);
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL carry_ripple: got %h/%b/%b, want 0000/1/0", sum, cout, ovf);
        end
        launch(16'h0000, 16'h0000, 1'b0, 1'b1);
        wait_done(n, bc);
        checks++;
        if (sum !== 16'h0001 || cout !== 1'b0) begin
            errors++;
            $display("FAIL carry_in: got %h/%b, want 0001/0", sum, cout);
        end
    endtask

    task automatic test_ovf();
        int n, bc;
        launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_done(n, bc);
        checks++;
        if (sum !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pos: got %h/%b/%b, want 8000/0/1", sum, cout, ovf);
        end
        launch(16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_done(n, bc);
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_neg: got %h/%b/%b, want 0000/1/1", sum, cout, ovf);
        end
    endtask

    task automatic test_sub();
        int n, bc;
        launch(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_done(n, bc);
        checks++;
        if (sum !== 16'hFFFE || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: got %h/%b/%b, want FFFE/0/0", sum, cout, ovf);
        end
        launch(16'h0007, 16'h0005, 1'b1, 1'b0);
        wait_done(n, bc);
        checks++;
        if (sum !== 16'h0002 || cout !== 1'b1) begin
            errors++;
            $display("FAIL sub_noborrow: got %h/%b, want 0002/1", sum, cout);
        end
        for (int i = 0; i < 4; i++) begin
            launch(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            wait_done(n, bc);
        end
    endtask

    task automatic test_ignore();
        int n, bc, extra;
        launch(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        a_in  = 16'hAAAA;
        b_in  = 16'hBBBB;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bc);
        checks++;
        if (sum !== 16'h3333) begin
            errors++;
            $display("FAIL ignore_result: got %h, want 3333", sum);
        end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL ignore_no_second: got %0d active cycles, want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        a_in  = 16'h0F0F;
        b_in  = 16'h0101;
        sub   = 1'b0;
        cin   = 1'b0;
        start = 1'b1;
        q.push_back(model(16'h0F0F, 16'h0101, 1'b0, 1'b0));
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        a_in = 16'h2000;
        b_in = 16'h0003;
        q.push_back(model(16'h2000, 16'h0003, 1'b0, 1'b0));
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b, want 1", busy);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            checks++;
            if (sum !== 16'h1010) begin
                errors++;
                $display("FAIL b2b_sum_stable: got %h, want 1010", sum);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 4 || sum !== 16'h2003) begin
            errors++;
            $display("FAIL b2b_second: got latency %0d sum %h, want 4 2003", n, sum);
        end
    endtask

    task automatic test_reset_mid();
        int n, bc, extra;
        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done(n, bc);
        checks++;
        if (sum !== 16'h5555) begin
            errors++;
            $display("FAIL rst_pre_sum: got %h, want 5555", sum);
        end
        launch(16'h0F00, 16'h00F0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sum, cout, ovf} !== 20'h0) begin
            errors++;
            $display("FAIL rst_async: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        void'(q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL rst_no_done: got %0d done pulses, want 0", extra);
        end
        launch(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_done(n, bc);
        checks++;
        if (n !== 4 || sum !== 16'h0002) begin
            errors++;
            $display("FAIL rst_fresh: got latency %0d sum %h, want 4 0002", n, sum);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_ovf();
        test_sub();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
